// File: rtl/nmi2apb_pkg.sv
// Shared types and constants for the NMI-to-APB4 bridge.
package nmi2apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam int         APB_DW        = 32;
  localparam int         APB_SW        = 4;
  localparam logic [2:0] APB_PPROT_DEF = 3'b000;

  // Width of the wait-state counter; never narrower than one bit.
  function automatic int cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nmi2apb_decoder.sv
// Priority base/mask address decoder: the lowest-index matching slave wins.
module nmi2apb_decoder
  import nmi2apb_pkg::*;
#(
  parameter int                    SLV_NUM  = 8,
  parameter logic [SLV_NUM*32-1:0] SLV_BASE = '0,
  parameter logic [SLV_NUM*32-1:0] SLV_MASK = '0
) (
  input  logic [APB_DW-1:0]  addr_i,
  output logic [SLV_NUM-1:0] sel_o,
  output logic               hit_o
);

  logic [SLV_NUM-1:0] match;

  for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_match
    assign match[gi] = (addr_i & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    sel_o = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

  assign hit_o = |match;

endmodule

// File: rtl/nmi2apb_bridge.sv
// NMI master to APB4 bridge with address decode, wait-state timeout and a
// sticky error record.
module nmi2apb_bridge
  import nmi2apb_pkg::*;
#(
  parameter int                    SLV_NUM     = 8,
  parameter int                    TIMEOUT_CYC = 1023,
  parameter logic [SLV_NUM*32-1:0] SLV_BASE    = '0,
  parameter logic [SLV_NUM*32-1:0] SLV_MASK    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_valid_i,
  input  logic [APB_DW-1:0]         mem_addr_i,
  input  logic [APB_DW-1:0]         mem_wdata_i,
  input  logic [APB_SW-1:0]         mem_wstrb_i,
  output logic [APB_DW-1:0]         mem_rdata_o,
  output logic                      mem_ready_o,
  output logic                      mem_err_o,
  output logic [APB_DW-1:0]         apb_paddr_o,
  output logic [2:0]                apb_pprot_o,
  output logic [SLV_NUM-1:0]        apb_psel_o,
  output logic                      apb_penable_o,
  output logic                      apb_pwrite_o,
  output logic [APB_DW-1:0]         apb_pwdata_o,
  output logic [APB_SW-1:0]         apb_pstrb_o,
  input  logic [SLV_NUM-1:0]        apb_pready_i,
  input  logic [SLV_NUM*APB_DW-1:0] apb_prdata_i,
  input  logic [SLV_NUM-1:0]        apb_pslverr_i,
  input  logic                      err_clr_i,
  output logic                      err_irq_o,
  output logic [APB_DW-1:0]         err_addr_o
);

  localparam int            CW      = cnt_width(TIMEOUT_CYC);
  localparam bit            TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e             state_q, state_d;
  logic [SLV_NUM-1:0] sel_q, sel_d;
  logic               penable_q, penable_d;
  logic [APB_DW-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [APB_DW-1:0]  pwdata_q, pwdata_d;
  logic [APB_SW-1:0]  pstrb_q, pstrb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [APB_DW-1:0]  rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               irq_q, irq_d;
  logic [APB_DW-1:0]  eaddr_q, eaddr_d;

  logic [SLV_NUM-1:0] dec_sel;
  logic               dec_hit;
  logic               sel_rdy, sel_err;
  logic [APB_DW-1:0]  sel_rdata;
  logic [APB_DW-1:0]  rdata_mask [SLV_NUM];
  logic               rec_err;
  logic [APB_DW-1:0]  rec_addr;

  nmi2apb_decoder #(
    .SLV_NUM  (SLV_NUM),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr_i (mem_addr_i),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // Only the selected slave's response lines reach the FSM.
  for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_rd
    assign rdata_mask[gi] = sel_q[gi] ? apb_prdata_i[APB_DW*gi +: APB_DW] : '0;
  end

  always_comb begin
    sel_rdy   = |(apb_pready_i & sel_q);
    sel_err   = |(apb_pslverr_i & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < SLV_NUM; i++) sel_rdata = sel_rdata | rdata_mask[i];
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rec_err   = 1'b0;
    rec_addr  = paddr_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i) begin
          if (dec_hit) begin
            paddr_d  = mem_addr_i;
            pwdata_d = mem_wdata_i;
            pstrb_d  = mem_wstrb_i;
            pwrite_d = |mem_wstrb_i;
            sel_d    = dec_sel;
            state_d  = ST_SETUP;
          end else begin
            rdata_d  = '0;
            err_d    = 1'b1;
            ready_d  = 1'b1;
            rec_err  = 1'b1;
            rec_addr = mem_addr_i;
            state_d  = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_rdy) begin
          rdata_d   = pwrite_q ? '0 : sel_rdata;
          err_d     = sel_err;
          rec_err   = sel_err;
          sel_d     = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          rec_err   = 1'b1;
          sel_d     = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error takes priority over a coincident clear.
    irq_d   = irq_q;
    eaddr_d = eaddr_q;
    if (rec_err) begin
      irq_d   = 1'b1;
      eaddr_d = rec_addr;
    end else if (err_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      eaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      eaddr_q   <= eaddr_d;
    end
  end

  assign mem_rdata_o   = rdata_q;
  assign mem_ready_o   = ready_q;
  assign mem_err_o     = err_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = APB_PPROT_DEF;
  assign apb_psel_o    = sel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_irq_o     = irq_q;
  assign err_addr_o    = eaddr_q;

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Scoreboard bench for nmi2apb_bridge: random NMI traffic against a
// transaction-level model of decode, latency, errors and the error record.
module tb_nmi2apb_bridge;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [N*32-1:0] BASES = {32'h0300_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000};
  localparam logic [N*32-1:0] MASKS = {32'hFF00_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          mem_valid_i = 1'b0;
  logic [31:0]   mem_addr_i = '0;
  logic [31:0]   mem_wdata_i = '0;
  logic [3:0]    mem_wstrb_i = '0;
  logic [31:0]   mem_rdata_o;
  logic          mem_ready_o;
  logic          mem_err_o;
  logic [31:0]   apb_paddr_o;
  logic [2:0]    apb_pprot_o;
  logic [N-1:0]  apb_psel_o;
  logic          apb_penable_o;
  logic          apb_pwrite_o;
  logic [31:0]   apb_pwdata_o;
  logic [3:0]    apb_pstrb_o;
  logic [N-1:0]  apb_pready_i = '0;
  logic [N*32-1:0] apb_prdata_i = '0;
  logic [N-1:0]  apb_pslverr_i = '0;
  logic          err_clr_i;
  logic          err_irq_o;
  logic [31:0]   err_addr_o;

  logic          clr_req = 1'b0;
  logic          clr_coinc = 1'b0;
  assign err_clr_i = clr_req | clr_coinc;

  nmi2apb_bridge #(
    .SLV_NUM     (N),
    .TIMEOUT_CYC (TO),
    .SLV_BASE    (BASES),
    .SLV_MASK    (MASKS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_valid_i   (mem_valid_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_wstrb_i   (mem_wstrb_i),
    .mem_rdata_o   (mem_rdata_o),
    .mem_ready_o   (mem_ready_o),
    .mem_err_o     (mem_err_o),
    .apb_paddr_o   (apb_paddr_o),
    .apb_pprot_o   (apb_pprot_o),
    .apb_psel_o    (apb_psel_o),
    .apb_penable_o (apb_penable_o),
    .apb_pwrite_o  (apb_pwrite_o),
    .apb_pwdata_o  (apb_pwdata_o),
    .apb_pstrb_o   (apb_pstrb_o),
    .apb_pready_i  (apb_pready_i),
    .apb_prdata_i  (apb_prdata_i),
    .apb_pslverr_i (apb_pslverr_i),
    .err_clr_i     (err_clr_i),
    .err_irq_o     (err_irq_o),
    .err_addr_o    (err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        irq;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        model_irq = 1'b0;
  logic [31:0] model_eaddr = '0;

  // Current request as seen by the slave models.
  int          cur_slv = -1;
  int          cur_wait = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] cur_rdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic        cur_slverr = 1'b0;
  logic        cur_clr = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int model_slave(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASKS[32*i +: 32]) == BASES[32*i +: 32]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Slave models: the modelled target answers after cur_wait ACCESS cycles,
  // every other slave drives random noise the bridge must ignore.
  initial begin : responder
    int   wc;
    int   sel_cyc;
    logic rdy_now;
    logic [N-1:0] exp_sel;
    wc = 0;
    sel_cyc = 0;
    forever begin
      @(negedge clk);
      rdy_now = (cur_slv >= 0) && (apb_psel_o != '0) && apb_penable_o && (wc == cur_wait);
      if (apb_psel_o != '0) begin
        exp_sel = (cur_slv >= 0) ? N'(1) << cur_slv : '0;
        total++;
        if (apb_psel_o !== exp_sel || apb_paddr_o !== cur_addr || apb_pwrite_o !== (|cur_wstrb) ||
            apb_pwdata_o !== cur_wdata || apb_pstrb_o !== cur_wstrb || apb_penable_o !== (sel_cyc > 0) ||
            apb_pprot_o !== 3'b000) begin
          bad++;
          $display("FAIL apb_phase got psel=%b addr=%h wr=%b wd=%h strb=%b en=%b want psel=%b addr=%h wr=%b wd=%h strb=%b en=%b",
                   apb_psel_o, apb_paddr_o, apb_pwrite_o, apb_pwdata_o, apb_pstrb_o, apb_penable_o,
                   exp_sel, cur_addr, |cur_wstrb, cur_wdata, cur_wstrb, sel_cyc > 0);
        end
        sel_cyc++;
      end else begin
        sel_cyc = 0;
      end
      if (apb_psel_o != '0 && apb_penable_o) wc++;
      else wc = 0;
      for (int i = 0; i < N; i++) begin
        if (i == cur_slv) begin
          apb_pready_i[i]            = rdy_now;
          apb_pslverr_i[i]           = rdy_now & cur_slverr;
          apb_prdata_i[32*i +: 32]   = cur_rdata;
        end else begin
          apb_pready_i[i]            = 1'($urandom);
          apb_pslverr_i[i]           = 1'($urandom);
          apb_prdata_i[32*i +: 32]   = $urandom;
        end
      end
      clr_coinc = rdy_now & cur_clr;
    end
  end

  // Monitor: pops the scoreboard on each completion, checks hold otherwise.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        last_rdata = '0;
      end else if (mem_ready_o) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready got ready=1 rdata=%h want no completion", mem_rdata_o);
        end else begin
          e = sbq.pop_front();
          if (mem_rdata_o !== e.rdata || mem_err_o !== e.err || cyc != e.cyc ||
              apb_psel_o != '0 || apb_penable_o !== 1'b0) begin
            bad++;
            $display("FAIL resp got rdata=%h err=%b cyc=%0d psel=%b en=%b want rdata=%h err=%b cyc=%0d psel=0 en=0",
                     mem_rdata_o, mem_err_o, cyc, apb_psel_o, apb_penable_o, e.rdata, e.err, e.cyc);
          end
          total++;
          if (err_irq_o !== e.irq || err_addr_o !== e.eaddr) begin
            bad++;
            $display("FAIL err_record got irq=%b addr=%h want irq=%b addr=%h",
                     err_irq_o, err_addr_o, e.irq, e.eaddr);
          end
          $display("txn resp rdata=%h err=%b cyc=%0d irq=%b", mem_rdata_o, mem_err_o, cyc, err_irq_o);
          last_rdata = e.rdata;
        end
      end else begin
        total++;
        if (mem_rdata_o !== last_rdata || mem_err_o !== 1'b0) begin
          bad++;
          $display("FAIL hold got rdata=%h err=%b want rdata=%h err=0", mem_rdata_o, mem_err_o, last_rdata);
        end
      end
    end
  end

  task automatic run_txn(input logic [31:0] a, input logic [3:0] s, input int w,
                         input logic se, input logic clr);
    exp_t        e;
    int          slv;
    logic [31:0] rd;
    logic [31:0] wd;
    logic        seen;
    rd  = $urandom;
    wd  = $urandom;
    slv = model_slave(a);
    @(negedge clk);
    cur_slv = slv; cur_addr = a; cur_wstrb = s; cur_wdata = wd;
    cur_wait = w; cur_slverr = se; cur_clr = clr; cur_rdata = rd;
    mem_valid_i = 1'b1; mem_addr_i = a; mem_wdata_i = wd; mem_wstrb_i = s;
    if (slv < 0) begin
      e.cyc = cyc + 1; e.err = 1'b1; e.rdata = '0;
    end else if (w >= TO) begin
      e.cyc = cyc + 2 + TO; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.cyc = cyc + 3 + w; e.err = se; e.rdata = (s != 4'b0) ? 32'h0 : rd;
    end
    if (e.err) begin
      model_irq = 1'b1;
      model_eaddr = a;
    end else if (clr && slv >= 0 && w < TO) begin
      model_irq = 1'b0;
    end
    e.irq = model_irq;
    e.eaddr = model_eaddr;
    sbq.push_back(e);
    $display("txn req addr=%h strb=%b wait=%0d slverr=%b slave=%0d", a, s, w, se, slv);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = mem_ready_o;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL txn_timeout addr=%h got no mem_ready_o want completion within 40 cycles", a);
      sbq.delete();
    end
    mem_valid_i = 1'b0;
    cur_clr = 1'b0;
  endtask

  task automatic clr_alone();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    model_irq = 1'b0;
    chk("irq_clear", 32'(err_irq_o), 32'(model_irq));
    chk("eaddr_keep", err_addr_o, model_eaddr);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no end of test want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [3:0]  s;
    int          w;
    int          k;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apb_psel_o), 32'h0);
    chk("rst_ready", 32'(mem_ready_o), 32'h0);
    rst_i = 1'b0;
    chk("rst_irq", 32'(err_irq_o), 32'h0);
    chk("rst_eaddr", err_addr_o, 32'h0);
    chk("rst_rdata", mem_rdata_o, 32'h0);
    chk("rst_penable", 32'(apb_penable_o), 32'h0);

    run_txn(32'h0300_0010, 4'b0000, 0, 1'b0, 1'b0);   // slave 2 zero-wait read
    run_txn(32'h0300_0020, 4'b0011, 3, 1'b0, 1'b0);   // write, 3 wait states
    run_txn(32'h0F00_0000, 4'b0000, 0, 1'b0, 1'b0);   // unmapped
    clr_alone();
    run_txn(32'h0200_0004, 4'b0000, 100, 1'b0, 1'b0); // timeout
    clr_alone();
    run_txn(32'h0100_0008, 4'b0000, 1, 1'b1, 1'b1);   // slave error with coincident clear
    clr_alone();
    run_txn(32'h0301_0000, 4'b1111, 0, 1'b0, 1'b0);   // overlap region goes to slave 3
    run_txn(32'h0100_0FFC, 4'b0000, TO - 1, 1'b0, 1'b0);
    run_txn(32'h0200_0FFC, 4'b0000, TO, 1'b0, 1'b0);
    clr_alone();

    // Reset mid-ACCESS: the transfer is dropped without a completion.
    @(negedge clk);
    cur_slv = 1; cur_addr = 32'h0200_0040; cur_wstrb = 4'b0000; cur_wdata = 32'h1234_5678;
    cur_wait = 100; cur_slverr = 1'b0; cur_clr = 1'b0;
    mem_valid_i = 1'b1; mem_addr_i = cur_addr; mem_wdata_i = cur_wdata; mem_wstrb_i = 4'b0000;
    repeat (2) @(negedge clk);
    chk("pen_before_rst", 32'(apb_penable_o), 32'h1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_async_psel", 32'(apb_psel_o), 32'h0);
    chk("rst_async_pen", 32'(apb_penable_o), 32'h0);
    mem_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_no_ready", 32'(mem_ready_o), 32'h0);
    chk("rst_rdata_clr", mem_rdata_o, 32'h0);
    rst_i = 1'b0;
    model_irq = 1'b0;
    model_eaddr = '0;
    run_txn(32'h0200_0040, 4'b0000, 2, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1, 2: a = {8'(k + 1), 12'h000, 12'($urandom_range(0, 4095))};
        3:       a = {8'h03, 8'($urandom_range(1, 255)), 16'($urandom)};
        4:       a = {16'h0F00, 16'($urandom)};
        default: a = $urandom;
      endcase
      s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 3);
      run_txn(a, s, w, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 9) == 0) clr_alone();
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nmi2apb_bridge.md
# nmi2apb_bridge

Parametrised bridge from the native memory interface (NMI) to an APB4 bus with a configurable number of slaves. It replaces the fixed-count bridge with per-slave read-data ports. It adds a base/mask address decoder, a per-transfer wait-state timeout, error reporting to the master and a sticky error record. It sits between the core-side NMI port and the peripheral APB slaves inside the peripheral wrapper.

## Interface
- SLV_NUM, 8: number of APB slaves, 1..16.
- TIMEOUT_CYC, 1023: maximum ACCESS cycles before abort; 0 disables the timeout.
- SLV_BASE, all 0: packed SLV_NUM×32 base addresses; slave i uses bits [32i+31:32i].
- SLV_MASK, all 0: packed SLV_NUM×32 masks; slave i matches when (addr & mask_i) == base_i.
- clk_i  in  1  bus clock.
- rst_i  in  1  reset; asynchronous, active-high.
- mem_valid_i  in  1  NMI request; held until mem_ready_o.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; zero means read.
- mem_rdata_o  out  32  read data, valid with mem_ready_o.
- mem_ready_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  error flag, qualified by mem_ready_o.
- apb_paddr_o  out  32  APB address.
- apb_pprot_o  out  3  fixed 3'b000.
- apb_psel_o  out  SLV_NUM  one-hot slave select.
- apb_penable_o  out  1  access phase.
- apb_pwrite_o  out  1  write transfer.
- apb_pwdata_o  out  32  write data.
- apb_pstrb_o  out  4  write strobes; 0 on reads.
- apb_pready_i  in  SLV_NUM  per-slave ready.
- apb_prdata_i  in  SLV_NUM×32  packed per-slave read data.
- apb_pslverr_i  in  SLV_NUM  per-slave error.
- err_clr_i  in  1  clears the sticky error record.
- err_irq_o  out  1  sticky error interrupt.
- err_addr_o  out  32  address of the most recent error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - When mem_valid_i=1, decode mem_addr_i. The lowest-index matching slave wins.
  - On a hit: latch address, data and strobes; set pwrite = |mem_wstrb_i; assert psel[hit]; go to SETUP.
  - On a miss (unmapped): no psel; set err=1, rdata=0; go to RESP.
- **SETUP**: assert penable; clear the timeout counter; go to ACCESS.
- **ACCESS**
  - Each cycle, sample pready[sel].
  - When pready[sel]=1: capture rdata = prdata[sel] on reads, or 0 on writes; set err = pslverr[sel]; drop psel and penable; go to RESP.
  - Otherwise increment the counter. If TIMEOUT_CYC≠0 and counter==TIMEOUT_CYC-1 with pready low: abort, drop psel and penable, set err=1, rdata=0, go to RESP.
- **RESP**: mem_ready_o=1 and mem_err_o=err for exactly one cycle; go to IDLE.
- Any error (slave error, unmapped address or timeout) sets err_irq_o and loads err_addr_o with the failing address.
  - err_clr_i clears err_irq_o.
  - If a new error and err_clr_i coincide, the error wins.
- Non-selected slaves' pready, prdata and pslverr are ignored.

## Timing
- Reset values: all outputs 0; FSM in IDLE; err_irq_o=0, err_addr_o=0.
- Reset is asynchronous and takes effect mid-transfer: psel and penable drop immediately, no mem_ready_o is issued, and the master must reissue the request.
- Latency, with mem_valid_i seen in IDLE at cycle 0:
  - Zero-wait slave: SETUP at cycle 1, ACCESS at cycle 2, mem_ready_o at cycle 3.
  - Each wait state adds one cycle.
  - Unmapped address: mem_ready_o at cycle 1.
  - Timeout: mem_ready_o at cycle 2+TIMEOUT_CYC.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the last ACCESS cycle.
- The cycle after RESP is always IDLE. A new mem_valid_i there starts a new transfer, giving back-to-back throughput of 4 cycles per zero-wait access.
- mem_rdata_o holds its value until the next RESP.

## Structure
- Package nmi2apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - localparams for the APB data width (32), strobe width (4) and default pprot;
  - a function for the timeout counter width, $clog2(TIMEOUT_CYC+1), minimum 1.
- Sub-module nmi2apb_decoder: combinational priority base/mask match producing a one-hot select plus a hit flag. The FSM and datapath stay in nmi2apb_bridge.

## Test plan
- SLV_NUM=4; slave 2 at base 0x0300_0000, mask 0xFFFF_F000; zero-wait read at 0x0300_0010 returning 0xDEAD_BEEF -> psel=4'b0100 for cycles 1–2, mem_ready_o at cycle 3 with rdata 0xDEADBEEF, mem_err_o=0.
- Write wstrb=4'b0011 with 3 wait states -> pstrb=4'b0011 and pwrite=1 held stable; mem_ready_o at cycle 6.
- Read of unmapped 0x0F00_0000 -> no psel; mem_ready_o at cycle 1 with rdata 0 and mem_err_o=1; err_irq_o=1 and err_addr_o=0x0F00_0000.
- TIMEOUT_CYC=8 with a slave that never raises pready -> psel dropped; mem_ready_o and mem_err_o at cycle 10.
- pslverr=1 with pready on slave 0, and err_clr_i pulsed in the same cycle that the error is recorded -> mem_err_o=1 and err_irq_o remains 1; a later err_clr_i alone clears it.
- rst_i asserted during ACCESS -> psel and penable go to 0 asynchronously; no mem_ready_o; after release, the next request completes normally.
